id_ex_stage: RTL

//  ID/EX pipeline register and operand-forwarding stage directly upstream of the ALU.

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/fwd_unit.sv | 32 +++
 rtl/id_ex_stage.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the ID/EX stage.
//   XLEN / CTRL_W / REG_AW : datapath, ALU-control and register-address widths
//   ALU control codes      : encodings driven on ALU_Control
//   sel_a_e / sel_b_e      : operand source selectors
//   id_ex_t                : one held decoded instruction
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 6;
  localparam int unsigned REG_AW = 5;

  localparam logic [CTRL_W-1:0] AluAdd = 6'h00;
  localparam logic [CTRL_W-1:0] AluSub = 6'h01;
  localparam logic [CTRL_W-1:0] AluAnd = 6'h02;
  localparam logic [CTRL_W-1:0] AluOr  = 6'h03;
  localparam logic [CTRL_W-1:0] AluXor = 6'h04;
  localparam logic [CTRL_W-1:0] AluSll = 6'h05;
  localparam logic [CTRL_W-1:0] AluSrl = 6'h06;
  localparam logic [CTRL_W-1:0] AluSra = 6'h07;

  typedef enum logic [1:0] {
    SelARs1  = 2'd0,
    SelAPc   = 2'd1,
    SelAZero = 2'd2,
    SelARsvd = 2'd3  // treated as zero
  } sel_a_e;

  typedef enum logic {
    SelBRs2 = 1'b0,
    SelBImm = 1'b1
  } sel_b_e;

  typedef struct packed {
    logic [CTRL_W-1:0] alu_ctrl;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    sel_a_e            sel_a;
    sel_b_e            sel_b;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
  } id_ex_t;

endpackage

// File: rtl/fwd_unit.sv
// Combinational priority forwarding mux for one source register.
//   rs_addr_i / rs_data_i : held source address and its stored value
//   exmem_*_i             : EX/MEM bus (highest priority)
//   memwb_*_i             : MEM/WB bus
//   fwd_data_o            : freshest value of the source register
module fwd_unit
  import cpu_pkg::*;
(
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [XLEN-1:0]   rs_data_i,
  input  logic              exmem_reg_write_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [XLEN-1:0]   exmem_result_i,
  input  logic              memwb_reg_write_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [XLEN-1:0]   memwb_data_i,
  output logic [XLEN-1:0]   fwd_data_o
);

  logic rs_nonzero;
  assign rs_nonzero = (rs_addr_i != '0);

  always_comb begin
    fwd_data_o = rs_data_i;
    if (exmem_reg_write_i && (exmem_rd_i == rs_addr_i) && rs_nonzero) begin
      fwd_data_o = exmem_result_i;
    end else if (memwb_reg_write_i && (memwb_rd_i == rs_addr_i) && rs_nonzero) begin
      fwd_data_o = memwb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, feeding the ALU.
//   clock/reset            : rising-edge clock, async active-high reset
//   in_* / in_valid/ready  : decoded instruction and its handshake
//   flush                  : squash held and incoming instruction
//   exmem_* / memwb_*      : forwarding buses from later stages
//   out_valid / out_ready  : handshake toward EX
//   ALU_Control, operand_A, operand_B : ALU inputs (zero on a bubble)
//   out_store_data, out_rd_addr, out_reg_write : passed downstream
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_alu_control,
  input  logic [REG_AW-1:0] in_rs1_addr,
  input  logic [REG_AW-1:0] in_rs2_addr,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [1:0]        in_sel_a,
  input  logic              in_sel_b,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic              in_reg_write,
  input  logic              flush,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [XLEN-1:0]   memwb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ALU_Control,
  output logic [XLEN-1:0]   operand_A,
  output logic [XLEN-1:0]   operand_B,
  output logic [XLEN-1:0]   out_store_data,
  output logic [REG_AW-1:0] out_rd_addr,
  output logic              out_reg_write
);

  logic            valid_q, valid_d;
  id_ex_t          entry_q, entry_d;
  logic            capture;
  logic [XLEN-1:0] src1, src2;

  assign in_ready = ~reset & (~valid_q | out_ready);
  assign capture  = in_valid & in_ready;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (flush) begin
      valid_d           = 1'b0;
      entry_d.reg_write = 1'b0;
    end else if (capture) begin
      valid_d            = 1'b1;
      entry_d.alu_ctrl   = in_alu_control;
      entry_d.rs1        = in_rs1_addr;
      entry_d.rs2        = in_rs2_addr;
      entry_d.rs1_data   = in_rs1_data;
      entry_d.rs2_data   = in_rs2_data;
      entry_d.imm        = in_imm;
      entry_d.pc         = in_pc;
      entry_d.sel_a      = sel_a_e'(in_sel_a);
      entry_d.sel_b      = sel_b_e'(in_sel_b);
      entry_d.rd         = in_rd_addr;
      entry_d.reg_write  = in_reg_write;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      // Stalled: a value retiring on MEM/WB now will be gone by the time we
      // are consumed, so fold it into the stored operand.
      if (memwb_reg_write && (memwb_rd == entry_q.rs1) && (entry_q.rs1 != '0)) begin
        entry_d.rs1_data = memwb_data;
      end
      if (memwb_reg_write && (memwb_rd == entry_q.rs2) && (entry_q.rs2 != '0)) begin
        entry_d.rs2_data = memwb_data;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  fwd_unit u_fwd_rs1 (
    .rs_addr_i         (entry_q.rs1),
    .rs_data_i         (entry_q.rs1_data),
    .exmem_reg_write_i (exmem_reg_write),
    .exmem_rd_i        (exmem_rd),
    .exmem_result_i    (exmem_result),
    .memwb_reg_write_i (memwb_reg_write),
    .memwb_rd_i        (memwb_rd),
    .memwb_data_i      (memwb_data),
    .fwd_data_o        (src1)
  );

  fwd_unit u_fwd_rs2 (
    .rs_addr_i         (entry_q.rs2),
    .rs_data_i         (entry_q.rs2_data),
    .exmem_reg_write_i (exmem_reg_write),
    .exmem_rd_i        (exmem_rd),
    .exmem_result_i    (exmem_result),
    .memwb_reg_write_i (memwb_reg_write),
    .memwb_rd_i        (memwb_rd),
    .memwb_data_i      (memwb_data),
    .fwd_data_o        (src2)
  );

  always_comb begin
    ALU_Control    = '0;
    operand_A      = '0;
    operand_B      = '0;
    out_store_data = '0;
    if (valid_q) begin
      ALU_Control    = entry_q.alu_ctrl;
      out_store_data = src2;
      unique case (entry_q.sel_a)
        SelARs1:            operand_A = src1;
        SelAPc:             operand_A = entry_q.pc;
        SelAZero, SelARsvd: operand_A = '0;
      endcase
      operand_B = (entry_q.sel_b == SelBImm) ? entry_q.imm : src2;
    end
  end

  assign out_valid     = valid_q;
  assign out_rd_addr   = entry_q.rd;
  assign out_reg_write = entry_q.reg_write;

endmodule
